instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory interface: drives the fetch address into the combinational instruction ROM and captures the returned 32-bit word.
- Buffers fetched words in a small in-order queue and presents them to decode with a valid/ready handshake.
- Follows unconditional J-type jumps locally (opcode 6'b000010).
- Accepts branch/jump redirects from execute, which flush the queue.

Parameters:
- DEPTH, 2, instruction queue entries (>=1).
- RESET_PC, 32'h00000000, fetch address after reset.
- FOLLOW_JUMP, 1, 1 = fetch redirects itself on opcode 000010; 0 = sequential fetch only.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- imem_addr  output  32  fetch address to instruction ROM; equals fetch_pc register.
- imem_data  input  32  ROM word for imem_addr, valid same cycle (combinational memory).
- redirect_valid  input  1  execute-stage redirect request (taken branch/jump).
- redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0).
- out_valid  output  1  queue head holds a valid instruction.
- out_ready  input  1  decode accepts head this cycle.
- out_instr  output  32  head instruction word.
- out_pc  output  32  address the head word was fetched from.
- out_jumped  output  1  head was a J-type that fetch already followed (decode must not redirect again).
- occupancy  output  $clog2(DEPTH+1)  number of valid queue entries.

Behaviour:
- Reset: fetch_pc = RESET_PC; queue empty; out_valid = 0, out_instr = 0, out_pc = 0, out_jumped = 0, occupancy = 0.
  - rst takes priority over all inputs.
  - rst asserted mid-operation discards all queued entries and any pending redirect.
- pop = out_valid & out_ready & ~redirect_valid.
- push = ~redirect_valid & ((occupancy < DEPTH) | pop).
  - Enqueue while full is allowed only when a pop happens in the same cycle.
- On push:
  - Write {imem_data, fetch_pc, jflag} at the tail.
  - jflag = FOLLOW_JUMP & (imem_data[31:26] == 6'b000010).
  - Next fetch_pc = jflag ? {pc_plus4[31:28], imem_data[25:0], 2'b00} : pc_plus4, where pc_plus4 = fetch_pc + 32'd4.
  - Modulo-2^32 wrap: 32'hFFFFFFFC -> 32'h00000000.
- No push: fetch_pc holds; imem_addr is unchanged, so the same word is re-read next cycle (no loss).
- Redirect (redirect_valid = 1, rst = 0):
  - Queue flushed: occupancy -> 0, out_valid = 0 next cycle.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No push and no pop that cycle; out_ready is ignored.
  - Redirect has priority over a simultaneous jflag.
  - First word from the new target is enqueued in the cycle after the redirect and is visible at out_* one cycle after that.
- Latency:
  - Word present on imem_data at cycle N appears on out_* at cycle N+1 if the queue was empty.
  - Steady state with out_ready = 1: one instruction per cycle.
- Ordering: strict FIFO. Head outputs come from registered queue storage (no combinational path imem_data -> out_*).
- out_instr / out_pc / out_jumped are don't-care when out_valid = 0, but must be 0 after reset.
- Queue implemented as circular buffer with read/write pointers wrapping at DEPTH; occupancy is updated +1 / -1 / 0 on push-only / pop-only / both-or-neither.
- All-zero word (ROM default) is an ordinary instruction (NOP); no special handling.

Test Plan:
- Reset then out_ready = 1, ROM: 0x0:8C000000, 0x4:20010005, 0x8:20020005 -> out_pc sequence 0,4,8 on consecutive cycles starting one cycle after reset release, out_instr matching, out_jumped = 0.
- Jump follow: word 0x08000006 at 0x10 -> imem_addr goes 0x10 -> 0x18 (0x14 never enqueued); head at 0x10 shows out_jumped = 1. With FOLLOW_JUMP = 0 -> 0x14 fetched next, out_jumped = 0.
- Backpressure: out_ready = 0 for 5 cycles from reset with DEPTH = 2 -> occupancy saturates at 2, imem_addr held at 0x8. Release -> 0x0, 0x4, 0x8 delivered in order with no duplicates or gaps.
- Redirect with full queue: occupancy 2, redirect_valid = 1, redirect_pc = 0x0000001B -> next cycle occupancy 0, imem_addr = 0x18. Following cycle out_pc = 0x18.
- Simultaneous events: redirect_valid = 1 while out_ready = 1 and the head word is a J-type -> no pop is counted, redirect target wins, queue empty afterwards. Then full + pop + push in one cycle -> occupancy stays 2.
- Wrap and reset mid-run: RESET_PC = 0xFFFFFFF8 -> out_pc FFFFFFF8, FFFFFFFC, 00000000. Asserting rst while occupancy = 2 -> out_valid = 0 next cycle, imem_addr = RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives a combinational ROM, follows J-type jumps locally, queues words in order for decode.
// Latency: a ROM word reaches out_* one cycle after it is presented, when the queue is empty.
// Backpressure: when the queue is full and decode stalls, fetch_pc holds and the same word is re-read.
module instr_fetch_unit #(
    parameter int          DEPTH       = 2,
    parameter logic [31:0] RESET_PC    = 32'h00000000,
    parameter bit          FOLLOW_JUMP = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_data,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    output logic                       out_jumped,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [31:0]    fetch_pc;
    logic [31:0]    q_instr [DEPTH];
    logic [31:0]    q_pc    [DEPTH];
    logic           q_jmp   [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [OW-1:0]  count;

    logic           pop;
    logic           push;
    logic           full;
    logic           jflag;
    logic [31:0]    pc_plus4;
    logic [31:0]    next_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full     = (count == OW'(DEPTH));
        pop      = out_valid & out_ready & ~redirect_valid;
        push     = ~redirect_valid & (~full | pop);
        jflag    = FOLLOW_JUMP & (imem_data[31:26] == 6'b000010);
        pc_plus4 = fetch_pc + 32'd4;
        // J-type target keeps the region bits of the sequential successor.
        next_pc  = jflag ? {pc_plus4[31:28], imem_data[25:0], 2'b00} : pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
                q_jmp[i]   <= 1'b0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~32'd3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                q_instr[wr_ptr] <= imem_data;
                q_pc[wr_ptr]    <= fetch_pc;
                q_jmp[wr_ptr]   <= jflag;
                wr_ptr          <= ptr_inc(wr_ptr);
                fetch_pc        <= next_pc;
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign imem_addr  = fetch_pc;
    assign out_valid  = (count != '0);
    assign out_instr  = q_instr[rd_ptr];
    assign out_pc     = q_pc[rd_ptr];
    assign out_jumped = q_jmp[rd_ptr];
    assign occupancy  = count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: three fetch units (default, no jump follow, wrapping reset PC) driven in lockstep.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic [31:0] a0, a1, a2;
    logic [31:0] i0, i1, i2;
    logic        v0, v1, v2;
    logic [31:0] oi0, oi1, oi2;
    logic [31:0] op0, op1, op2;
    logic        oj0, oj1, oj2;
    logic [1:0]  oc0, oc1, oc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h00000000: rom = 32'h8C000000;
            32'h00000004: rom = 32'h20010005;
            32'h00000008: rom = 32'h20020005;
            32'h0000000C: rom = 32'h00000000;
            32'h00000010: rom = 32'h08000006;
            32'h00000014: rom = 32'h11111111;
            32'h00000018: rom = 32'h22222222;
            32'h0000001C: rom = 32'h33333333;
            default:      rom = {8'hA5, a[23:0]};
        endcase
    endfunction

    assign i0 = rom(a0);
    assign i1 = rom(a1);
    assign i2 = rom(a2);

    instr_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0), .FOLLOW_JUMP(1'b1)) u0 (
        .clk(clk), .rst(rst), .imem_addr(a0), .imem_data(i0),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(v0), .out_ready(out_ready), .out_instr(oi0), .out_pc(op0),
        .out_jumped(oj0), .occupancy(oc0));

    instr_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0), .FOLLOW_JUMP(1'b0)) u1 (
        .clk(clk), .rst(rst), .imem_addr(a1), .imem_data(i1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(v1), .out_ready(out_ready), .out_instr(oi1), .out_pc(op1),
        .out_jumped(oj1), .occupancy(oc1));

    instr_fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFFFFF8), .FOLLOW_JUMP(1'b1)) u2 (
        .clk(clk), .rst(rst), .imem_addr(a2), .imem_data(i2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(v2), .out_ready(out_ready), .out_instr(oi2), .out_pc(op2),
        .out_jumped(oj2), .occupancy(oc2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_valid",   32'(v0),  32'd0);
        chk("rst_instr",   oi0,      32'd0);
        chk("rst_pc",      op0,      32'd0);
        chk("rst_jumped",  32'(oj0), 32'd0);
        chk("rst_occ",     32'(oc0), 32'd0);
        chk("rst_addr",    a0,       32'h0);
        chk("rst_addr_u2", a2,       32'hFFFFFFF8);
        chk("rst_pc_u2",   op2,      32'd0);

        // Streaming with decode always ready.
        rst = 1'b0; out_ready = 1'b1;
        step();
        chk("s0_valid",  32'(v0),  32'd1);
        chk("s0_pc",     op0,      32'h0);
        chk("s0_instr",  oi0,      32'h8C000000);
        chk("s0_occ",    32'(oc0), 32'd1);
        chk("w0_pc",     op2,      32'hFFFFFFF8);
        step();
        chk("s1_pc",     op0,      32'h4);
        chk("s1_instr",  oi0,      32'h20010005);
        chk("w1_pc",     op2,      32'hFFFFFFFC);
        step();
        chk("s2_pc",     op0,      32'h8);
        chk("s2_instr",  oi0,      32'h20020005);
        chk("s2_jumped", 32'(oj0), 32'd0);
        chk("w2_pc",     op2,      32'h00000000);
        chk("w2_instr",  oi2,      32'h8C000000);

        // Backpressure from reset: queue saturates, fetch address holds.
        rst = 1'b1; out_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("bp1_occ",  32'(oc0), 32'd1);
        chk("bp1_addr", a0,       32'h4);
        for (int k = 0; k < 4; k++) step();
        chk("bp_occ",   32'(oc0), 32'd2);
        chk("bp_addr",  a0,       32'h8);
        chk("bp_head",  op0,      32'h0);
        out_ready = 1'b1;
        step();
        chk("bp_r0_pc",  op0,      32'h4);
        chk("bp_r0_occ", 32'(oc0), 32'd2);
        step();
        chk("bp_r1_pc",    op0, 32'h8);
        chk("bp_r1_instr", oi0, 32'h20020005);
        step();
        chk("bp_r2_pc",    op0,      32'hC);
        chk("bp_r2_instr", oi0,      32'h0);
        chk("bp_r2_occ",   32'(oc0), 32'd2);

        // Redirect with a full queue; low address bits are dropped.
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000001B;
        step();
        chk("rd_occ",   32'(oc0), 32'd0);
        chk("rd_valid", 32'(v0),  32'd0);
        chk("rd_addr",  a0,       32'h18);
        redirect_valid = 1'b0;
        step();
        chk("rd_t_valid", 32'(v0), 32'd1);
        chk("rd_t_pc",    op0,     32'h18);
        chk("rd_t_instr", oi0,     32'h22222222);

        // Jump follow versus sequential fetch.
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        step();
        chk("j_addr", a0, 32'h10);
        redirect_valid = 1'b0;
        step();
        chk("j_addr_next",  a0,       32'h18);
        chk("j_head_pc",    op0,      32'h10);
        chk("j_jumped",     32'(oj0), 32'd1);
        chk("nj_addr_next", a1,       32'h14);
        chk("nj_jumped",    32'(oj1), 32'd0);
        step();
        chk("j_occ", 32'(oc0), 32'd2);
        out_ready = 1'b1;
        step();
        chk("j_second_pc",    op0,      32'h18);
        chk("j_second_instr", oi0,      32'h22222222);
        chk("j_second_jmp",   32'(oj0), 32'd0);
        chk("nj_second_pc",   op1,      32'h14);

        // Redirect while ready and a J-type at the head: redirect wins, nothing popped.
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h10;
        step();
        redirect_valid = 1'b0;
        step();
        chk("sim_head_jmp", 32'(oj0), 32'd1);
        chk("sim_occ_pre",  32'(oc0), 32'd1);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h4;
        step();
        chk("sim_occ",   32'(oc0), 32'd0);
        chk("sim_valid", 32'(v0),  32'd0);
        chk("sim_addr",  a0,       32'h4);
        redirect_valid = 1'b0;
        step();
        chk("sim_t_pc", op0, 32'h4);

        // Reset while full, with a redirect pending in the same cycle.
        out_ready = 1'b0;
        step(); step();
        chk("mr_occ_pre", 32'(oc0), 32'd2);
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h18;
        step();
        chk("mr_valid",   32'(v0),  32'd0);
        chk("mr_occ",     32'(oc0), 32'd0);
        chk("mr_addr",    a0,       32'h0);
        chk("mr_instr",   oi0,      32'h0);
        chk("mr_addr_u2", a2,       32'hFFFFFFF8);
        rst = 1'b0; redirect_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
